// File: rtl/gate_checker_if.sv
// Bundle between the inverter checker and its test harness: run control, stimulus/response, results.
// The master side drives start and the inverter output; the slave side is the checker.
interface gate_checker_if #(
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8
);
  localparam int IDX_W = $clog2(NUM_VECTORS);

  logic             start;
  logic             dut_y;
  logic             dut_a;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [IDX_W-1:0] first_fail_idx;
  logic             first_fail_valid;

  modport master (
    output start, dut_y,
    input  dut_a, busy, done, pass_cnt, fail_cnt, first_fail_idx, first_fail_valid
  );

  modport slave (
    input  start, dut_y,
    output dut_a, busy, done, pass_cnt, fail_cnt, first_fail_idx, first_fail_valid
  );
endinterface

// File: rtl/gate_checker.sv
// Drives alternating 0/1 vectors into an inverter and counts matches; each vector takes
// SETTLE_CYCLES+2 cycles, done pulses one cycle after the last sample; no backpressure.
module gate_checker #(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_checker_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_VECTORS);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SET_W-1:0] settle_cnt;
  logic             dut_a;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [IDX_W-1:0] first_fail_idx;
  logic             first_fail_valid;
  logic             vec_pass;

  // Case equality so an X or Z response is never mistaken for a pass.
  assign vec_pass = (bus.dut_y === ~dut_a);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      settle_cnt       <= '0;
      dut_a            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state            <= DRIVE;
            busy             <= 1'b1;
            idx              <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          dut_a      <= idx[0];
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          // Counters stick at all-ones rather than wrapping back to a misleading small value.
          if (vec_pass) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (!first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_a            = dut_a;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass_cnt         = pass_cnt;
  assign bus.fail_cnt         = fail_cnt;
  assign bus.first_fail_idx   = first_fail_idx;
  assign bus.first_fail_valid = first_fail_valid;
endmodule

// File: tb/tb_gate_checker.sv
// Randomized scoreboard bench: a main checker (4 vectors) and a narrow-counter checker (6 vectors, 2-bit counts).
module tb_gate_checker;
  localparam int SC   = 2;
  localparam int NM   = 4;
  localparam int CWM  = 8;
  localparam int NS   = 6;
  localparam int CWS  = 2;
  localparam int VLEN = SC + 2;

  typedef struct {
    int pass_n;
    int fail_n;
    int ffi;
    int ffv;
    int last_a;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] tt_m = 2'b01;
  logic [1:0] tt_s = 2'b01;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int busy_m = 0;
  int busy_s = 0;
  int done_seen_m = 0;
  exp_t sb_m[$];
  exp_t sb_s[$];
  exp_t em;
  exp_t es;

  gate_checker_if #(.NUM_VECTORS(NM), .CNT_W(CWM)) m_if ();
  gate_checker_if #(.NUM_VECTORS(NS), .CNT_W(CWS)) s_if ();

  // tt[a] is the response the gate gives to input a.
  assign m_if.dut_y = tt_m[m_if.dut_a];
  assign s_if.dut_y = tt_s[s_if.dut_a];

  gate_checker #(.NUM_VECTORS(NM), .SETTLE_CYCLES(SC), .CNT_W(CWM)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(m_if)
  );
  gate_checker #(.NUM_VECTORS(NS), .SETTLE_CYCLES(SC), .CNT_W(CWS)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: vector i drives a = i mod 2; it passes when the gate output differs from a.
  function automatic exp_t model(input int n, input int cw, input logic [1:0] tt, input int done_cyc);
    exp_t e;
    int cmax;
    cmax = (1 << cw) - 1;
    e.pass_n = 0; e.fail_n = 0; e.ffi = 0; e.ffv = 0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = i % 2;
      if (int'(tt[a]) != a) begin
        if (e.pass_n < cmax) e.pass_n++;
      end else begin
        if (e.fail_n < cmax) e.fail_n++;
        if (e.ffv == 0) begin e.ffv = 1; e.ffi = i; end
      end
    end
    e.last_a = (n - 1) % 2;
    e.done_cyc = done_cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!m_if.busy && !m_if.done) busy_m = 0;
    else if (m_if.busy) busy_m++;
    if (m_if.done) begin
      done_seen_m++;
      if (sb_m.size() == 0) begin
        total++; bad++;
        $display("FAIL main_unexpected_done: got done=1 expected no pending run");
      end else begin
        em = sb_m.pop_front();
        check("main_pass_cnt", int'(m_if.pass_cnt), em.pass_n);
        check("main_fail_cnt", int'(m_if.fail_cnt), em.fail_n);
        check("main_ff_idx", int'(m_if.first_fail_idx), em.ffi);
        check("main_ff_valid", int'(m_if.first_fail_valid), em.ffv);
        check("main_done_cycle", cyc, em.done_cyc);
        check("main_busy_len", busy_m, NM * VLEN);
        check("main_last_a", int'(m_if.dut_a), em.last_a);
      end
      busy_m = 0;
    end
  end

  always @(negedge clk) begin
    if (!s_if.busy && !s_if.done) busy_s = 0;
    else if (s_if.busy) busy_s++;
    if (s_if.done) begin
      if (sb_s.size() == 0) begin
        total++; bad++;
        $display("FAIL sat_unexpected_done: got done=1 expected no pending run");
      end else begin
        es = sb_s.pop_front();
        check("sat_pass_cnt", int'(s_if.pass_cnt), es.pass_n);
        check("sat_fail_cnt", int'(s_if.fail_cnt), es.fail_n);
        check("sat_ff_idx", int'(s_if.first_fail_idx), es.ffi);
        check("sat_ff_valid", int'(s_if.first_fail_valid), es.ffv);
        check("sat_done_cycle", cyc, es.done_cyc);
        check("sat_busy_len", busy_s, NS * VLEN);
        check("sat_last_a", int'(s_if.dut_a), es.last_a);
      end
      busy_s = 0;
    end
  end

  // Raises start so the next rising edge samples it; returns the cycle count of that edge.
  task automatic do_start(input bit sat, input logic [1:0] tt, input bit push, input bit keep, output int c0);
    @(negedge clk);
    if (sat) begin tt_s = tt; s_if.start = 1'b1; end
    else begin tt_m = tt; m_if.start = 1'b1; end
    @(negedge clk);
    c0 = cyc;
    if (!keep) begin m_if.start = 1'b0; s_if.start = 1'b0; end
    if (push) begin
      if (sat) sb_s.push_back(model(NS, CWS, tt, c0 + NS * VLEN));
      else sb_m.push_back(model(NM, CWM, tt, c0 + NM * VLEN));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_m.size() != 0 || sb_s.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_m.size() != 0 || sb_s.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d pending runs expected 0", sb_m.size() + sb_s.size());
      sb_m.delete();
      sb_s.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done_main(output int d);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_if.done) begin d = cyc; break; end
    end
    if (d < 0) begin
      total++; bad++;
      $display("FAIL wait_done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic check_zero_main(input string tag);
    check({tag, "_dut_a"}, int'(m_if.dut_a), 0);
    check({tag, "_busy"}, int'(m_if.busy), 0);
    check({tag, "_done"}, int'(m_if.done), 0);
    check({tag, "_pass"}, int'(m_if.pass_cnt), 0);
    check({tag, "_fail"}, int'(m_if.fail_cnt), 0);
    check({tag, "_ffi"}, int'(m_if.first_fail_idx), 0);
    check({tag, "_ffv"}, int'(m_if.first_fail_valid), 0);
  endtask

  initial begin
    int c0;
    int d;
    int dn0;
    m_if.start = 1'b1;
    s_if.start = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_main("reset");
    check("reset_sat_busy", int'(s_if.busy), 0);
    check("reset_sat_pass", int'(s_if.pass_cnt), 0);
    rst_n = 1'b1;
    m_if.start = 1'b0;
    s_if.start = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", int'(m_if.busy), 0);

    // Ideal inverter, stuck-at-0, then buffer twice (results cleared by the second start).
    do_start(1'b0, 2'b01, 1'b1, 1'b0, c0); wait_idle();
    do_start(1'b0, 2'b00, 1'b1, 1'b0, c0); wait_idle();
    do_start(1'b0, 2'b10, 1'b1, 1'b0, c0); wait_idle();
    do_start(1'b0, 2'b10, 1'b1, 1'b0, c0); wait_idle();

    // start held high across a whole run: a second run begins two edges after done.
    do_start(1'b0, 2'b01, 1'b1, 1'b1, c0);
    wait_done_main(d);
    if (d >= 0) sb_m.push_back(model(NM, CWM, 2'b01, d + 2 + NM * VLEN));
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_if.start = 1'b0;
    wait_idle();

    // start raised only while in DONE must not launch a run.
    do_start(1'b0, 2'b00, 1'b1, 1'b0, c0);
    wait_done_main(d);
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    check("start_in_done_ignored_a", int'(m_if.busy), 0);
    @(negedge clk);
    check("start_in_done_ignored_b", int'(m_if.busy), 0);
    check("results_hold_pass", int'(m_if.pass_cnt), 2);
    check("results_hold_dut_a", int'(m_if.dut_a), 1);
    wait_idle();

    // Reset during SETTLE of vector 2.
    do_start(1'b0, 2'b01, 1'b0, 1'b0, c0);
    while (cyc < c0 + 2 * VLEN + 1) @(negedge clk);
    check("pre_reset_busy", int'(m_if.busy), 1);
    check("pre_reset_pass", int'(m_if.pass_cnt), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_main("midrun_reset");
    dn0 = done_seen_m;
    repeat (3 * NM * VLEN) @(negedge clk);
    check("no_done_after_reset", done_seen_m - dn0, 0);

    for (int r = 0; r < 8; r++) begin
      do_start(1'b0, 2'($urandom_range(0, 3)), 1'b1, 1'b0, c0);
      wait_idle();
    end

    // Narrow counters: saturation at 3.
    do_start(1'b1, 2'b01, 1'b1, 1'b0, c0); wait_idle();
    do_start(1'b1, 2'b10, 1'b1, 1'b0, c0); wait_idle();
    for (int r = 0; r < 3; r++) begin
      do_start(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0, c0);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
